code_verifier: RTL and testbench
================================

Name: code_verifier

Overview:
Consumer side of the safe's one-time code path. Snapshots the 4-digit decimal code from the random generator when armed, then collects user keypad digits and compares the entered code against the snapshot. Drives the unlock, fail and lockout status to the top-level safe controller and display.
Enforces a bounded number of attempts, followed by a timed lockout.

Parameters:
MAX_ATTEMPTS, 3, wrong entries allowed before lockout (1..15)
LOCK_CYCLES, 50000000, lockout duration in clk cycles (>=1; 32-bit internal counter)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
arm  input  1  1-cycle pulse: latch ref_d1..ref_d4 as the active code
ref_d1  input  4  reference thousands digit (0-9)
ref_d2  input  4  reference hundreds digit
ref_d3  input  4  reference tens digit
ref_d4  input  4  reference units digit
key_valid  input  1  1-cycle strobe: key_code valid
key_code  input  4  0-9 digit, 0xA CLEAR, 0xB ENTER, 0xC RELOCK, 0xD-0xF ignored
disp_d1..disp_d4  output  4 each  entered digits, first key in disp_d1; 0xF = blank
entry_cnt  output  3  digits entered (0-4)
armed  output  1  a code is latched (state != IDLE)
unlocked  output  1  level, high in OPEN
unlock_pulse  output  1  1-cycle pulse on correct code
fail_pulse  output  1  1-cycle pulse on wrong code
locked_out  output  1  level, high in LOCKOUT
attempts_left  output  4  remaining attempts

Behaviour:
- All outputs registered. Reset (rst_n=0 at a clk edge) has priority over everything, including mid-lockout and mid-check.
- Reset values: state IDLE, disp_d1..d4=0xF, entry_cnt=0, armed=0, unlocked=0, unlock_pulse=0, fail_pulse=0, locked_out=0, attempts_left=MAX_ATTEMPTS, lock counter=0, code snapshot=0.
- States: IDLE, ENTRY, CHECK, OPEN, LOCKOUT.
- arm in IDLE, ENTRY or OPEN:
  - snapshot ref_d1..d4, clear the buffer to 0xF, set entry_cnt=0 and attempts_left=MAX_ATTEMPTS, go to ENTRY next cycle.
  - arm is ignored in LOCKOUT and CHECK.
  - arm and key_valid in the same cycle: arm wins and the key is dropped.
- ref_d* are sampled only on arm. Later changes have no effect.
- IDLE: all keys ignored.
- ENTRY, key handling:
  - Digit with entry_cnt<4: write it to disp_d(entry_cnt+1), then entry_cnt+1. Digit with entry_cnt=4: ignored.
  - CLEAR: buffer to 0xF, entry_cnt=0.
  - ENTER with entry_cnt=4: go to CHECK. ENTER with entry_cnt<4: ignored, no attempt consumed.
  - RELOCK and 0xD-0xF: ignored.
- CHECK lasts exactly 1 cycle and ignores keys. It compares all 4 digits against the snapshot.
  - Match: go to OPEN. unlocked=1 and unlock_pulse=1 in the first OPEN cycle, so the pulse appears 2 cycles after the ENTER edge.
  - Mismatch: fail_pulse=1 for 1 cycle, attempts_left decrements, buffer cleared, entry_cnt=0.
    - New attempts_left>0: go to ENTRY.
    - New attempts_left=0: go to LOCKOUT, load the lock counter with LOCK_CYCLES, locked_out=1.
- OPEN:
  - RELOCK key: go to ENTRY, unlocked=0, buffer cleared, attempts_left=MAX_ATTEMPTS, same snapshot kept.
  - Other keys ignored.
- LOCKOUT:
  - locked_out=1 for exactly LOCK_CYCLES cycles. The counter decrements every cycle and all keys are ignored.
  - When the counter reaches 0: go to ENTRY, locked_out=0, attempts_left=MAX_ATTEMPTS, same snapshot kept.
- unlock_pulse and fail_pulse are never high together, and never high for more than 1 cycle.
- Comparison is 4-bit exact equality per digit; there is no range check on the snapshot.

Test Plan:
- Reset then idle:
  - Expected: all outputs at reset values.
  - Keys 1,2,3,4,ENTER while in IDLE: no state change, entry_cnt stays 0.
- arm with ref=4,7,0,9, then keys 4,7,0,9,ENTER:
  - disp shows 4,7,0,9 and entry_cnt=4.
  - unlock_pulse high exactly 1 cycle, 2 cycles after the ENTER edge. unlocked stays 1.
  - RELOCK: unlocked=0, entry_cnt=0.
- MAX_ATTEMPTS=3, LOCK_CYCLES=8, three wrong codes (1,1,1,1):
  - 3 fail_pulses; attempts_left 2, 1, 0.
  - locked_out high for exactly 8 cycles, with keys and arm ignored.
  - Then ENTRY with attempts_left=3; the correct code now unlocks.
- Entry edge cases:
  - 5th digit ignored.
  - ENTER with 3 digits: no fail_pulse.
  - CLEAR after 2 digits: disp all 0xF, entry_cnt=0.
  - Re-enter the code correctly: unlock.
- Snapshot and priority:
  - Change ref_d* after arm: the originally latched code still unlocks, the new code fails.
  - arm and key_valid in the same cycle: key dropped.
- Reset mid-LOCKOUT and mid-CHECK: next cycle all outputs at reset values and armed=0.

Source files
------------

// File: rtl/code_verifier.sv
// code_verifier: latches a one-time 4-digit code on arm, collects keypad digits and
// unlocks on a match, with bounded attempts followed by a timed lockout.
module code_verifier #(
    parameter int unsigned MAX_ATTEMPTS = 3,
    parameter int unsigned LOCK_CYCLES  = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arm,
    input  logic [3:0] ref_d1,
    input  logic [3:0] ref_d2,
    input  logic [3:0] ref_d3,
    input  logic [3:0] ref_d4,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] disp_d1,
    output logic [3:0] disp_d2,
    output logic [3:0] disp_d3,
    output logic [3:0] disp_d4,
    output logic [2:0] entry_cnt,
    output logic       armed,
    output logic       unlocked,
    output logic       unlock_pulse,
    output logic       fail_pulse,
    output logic       locked_out,
    output logic [3:0] attempts_left
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ENTRY = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_OPEN  = 3'd3;
    localparam logic [2:0] S_LOCK  = 3'd4;
    localparam logic [3:0] K_CLEAR  = 4'hA;
    localparam logic [3:0] K_ENTER  = 4'hB;
    localparam logic [3:0] K_RELOCK = 4'hC;
    localparam logic [3:0] ATT_MAX  = 4'(MAX_ATTEMPTS);
    localparam logic [31:0] LOCK_MAX = 32'(LOCK_CYCLES);

    logic [2:0]      state_q, state_d;
    logic [3:0][3:0] code_q, code_d;
    logic [3:0][3:0] disp_q, disp_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [3:0]      att_q, att_d;
    logic [31:0]     lock_q, lock_d;
    logic            unlock_pulse_q, unlock_pulse_d;
    logic            fail_pulse_q, fail_pulse_d;
    logic            armed_q, armed_d;
    logic            unlocked_q, unlocked_d;
    logic            locked_q, locked_d;
    logic            is_digit;
    logic [3:0]      att_dec;

    assign is_digit = key_code < 4'd10;
    assign att_dec  = att_q - 4'd1;

    always_comb begin
        state_d        = state_q;
        code_d         = code_q;
        disp_d         = disp_q;
        cnt_d          = cnt_q;
        att_d          = att_q;
        lock_d         = lock_q;
        unlock_pulse_d = 1'b0;
        fail_pulse_d   = 1'b0;
        // arm outranks any key in the same cycle; CHECK and LOCKOUT are not re-armable
        if (arm && (state_q == S_IDLE || state_q == S_ENTRY || state_q == S_OPEN)) begin
            state_d = S_ENTRY;
            code_d  = {ref_d4, ref_d3, ref_d2, ref_d1};
            disp_d  = '1;
            cnt_d   = 3'd0;
            att_d   = ATT_MAX;
        end else begin
            case (state_q)
                S_ENTRY: if (key_valid) begin
                    if (is_digit) begin
                        if (cnt_q < 3'd4) begin
                            disp_d[cnt_q[1:0]] = key_code;
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else if (key_code == K_CLEAR) begin
                        disp_d = '1;
                        cnt_d  = 3'd0;
                    end else if (key_code == K_ENTER && cnt_q == 3'd4) begin
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: if (disp_q == code_q) begin
                    state_d        = S_OPEN;
                    unlock_pulse_d = 1'b1;
                end else begin
                    fail_pulse_d = 1'b1;
                    att_d        = att_dec;
                    disp_d       = '1;
                    cnt_d        = 3'd0;
                    state_d      = (att_dec == 4'd0) ? S_LOCK : S_ENTRY;
                    lock_d       = (att_dec == 4'd0) ? LOCK_MAX : lock_q;
                end
                S_OPEN: if (key_valid && key_code == K_RELOCK) begin
                    state_d = S_ENTRY;
                    disp_d  = '1;
                    cnt_d   = 3'd0;
                    att_d   = ATT_MAX;
                end
                S_LOCK: begin
                    lock_d = lock_q - 32'd1;
                    if (lock_q <= 32'd1) begin
                        state_d = S_ENTRY;
                        att_d   = ATT_MAX;
                    end
                end
                default: ;
            endcase
        end
    end

    assign armed_d    = state_d != S_IDLE;
    assign unlocked_d = state_d == S_OPEN;
    assign locked_d   = state_d == S_LOCK;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            code_q         <= '0;
            disp_q         <= '1;
            cnt_q          <= 3'd0;
            att_q          <= ATT_MAX;
            lock_q         <= 32'd0;
            unlock_pulse_q <= 1'b0;
            fail_pulse_q   <= 1'b0;
            armed_q        <= 1'b0;
            unlocked_q     <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            code_q         <= code_d;
            disp_q         <= disp_d;
            cnt_q          <= cnt_d;
            att_q          <= att_d;
            lock_q         <= lock_d;
            unlock_pulse_q <= unlock_pulse_d;
            fail_pulse_q   <= fail_pulse_d;
            armed_q        <= armed_d;
            unlocked_q     <= unlocked_d;
            locked_q       <= locked_d;
        end
    end

    assign disp_d1       = disp_q[0];
    assign disp_d2       = disp_q[1];
    assign disp_d3       = disp_q[2];
    assign disp_d4       = disp_q[3];
    assign entry_cnt     = cnt_q;
    assign armed         = armed_q;
    assign unlocked      = unlocked_q;
    assign unlock_pulse  = unlock_pulse_q;
    assign fail_pulse    = fail_pulse_q;
    assign locked_out    = locked_q;
    assign attempts_left = att_q;
endmodule

// File: tb/tb_code_verifier.sv
// tb_code_verifier: directed and random stimulus for code_verifier, every output compared
// each cycle against a queue-based model of the keypad/attempt/lockout rules.
module tb_code_verifier;
    localparam int MAXA = 3;
    localparam int LOCKC = 8;
    localparam logic [3:0] CLR = 4'hA, ENT = 4'hB, RLK = 4'hC;

    logic clk = 1'b0;
    logic rst_n, arm, key_valid;
    logic [3:0] ref_d1, ref_d2, ref_d3, ref_d4, key_code;
    logic [3:0] disp_d1, disp_d2, disp_d3, disp_d4, attempts_left;
    logic [2:0] entry_cnt;
    logic armed, unlocked, unlock_pulse, fail_pulse, locked_out;

    int n_checks = 0;
    int n_pass = 0;

    int ent[$];
    int snap[4];
    bit m_armed, m_open, m_check, m_up, m_fp;
    int m_lock, m_att;

    always #5 clk = ~clk;

    code_verifier #(.MAX_ATTEMPTS(MAXA), .LOCK_CYCLES(LOCKC)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm),
        .ref_d1(ref_d1), .ref_d2(ref_d2), .ref_d3(ref_d3), .ref_d4(ref_d4),
        .key_valid(key_valid), .key_code(key_code),
        .disp_d1(disp_d1), .disp_d2(disp_d2), .disp_d3(disp_d3), .disp_d4(disp_d4),
        .entry_cnt(entry_cnt), .armed(armed), .unlocked(unlocked),
        .unlock_pulse(unlock_pulse), .fail_pulse(fail_pulse),
        .locked_out(locked_out), .attempts_left(attempts_left)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        ent.delete();
        snap = '{0, 0, 0, 0};
        m_armed = 0; m_open = 0; m_check = 0; m_up = 0; m_fp = 0;
        m_lock = 0; m_att = MAXA;
    endtask

    task automatic model_step();
        m_up = 0;
        m_fp = 0;
        if (m_check) begin
            m_check = 0;
            if (ent[0] == snap[0] && ent[1] == snap[1] && ent[2] == snap[2] && ent[3] == snap[3]) begin
                m_open = 1;
                m_up = 1;
            end else begin
                m_fp = 1;
                m_att--;
                ent.delete();
                if (m_att == 0) m_lock = LOCKC;
            end
        end else if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_att = MAXA;
        end else if (arm) begin
            snap = '{int'(ref_d1), int'(ref_d2), int'(ref_d3), int'(ref_d4)};
            ent.delete();
            m_att = MAXA;
            m_armed = 1;
            m_open = 0;
        end else if (m_armed && key_valid) begin
            if (m_open) begin
                if (key_code == RLK) begin
                    m_open = 0;
                    ent.delete();
                    m_att = MAXA;
                end
            end else if (key_code < 10) begin
                if (ent.size() < 4) ent.push_back(int'(key_code));
            end else if (key_code == CLR) begin
                ent.delete();
            end else if (key_code == ENT && ent.size() == 4) begin
                m_check = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("disp_d1", disp_d1, ent.size() > 0 ? ent[0] : 15);
        chk("disp_d2", disp_d2, ent.size() > 1 ? ent[1] : 15);
        chk("disp_d3", disp_d3, ent.size() > 2 ? ent[2] : 15);
        chk("disp_d4", disp_d4, ent.size() > 3 ? ent[3] : 15);
        chk("entry_cnt", entry_cnt, ent.size());
        chk("armed", armed, m_armed);
        chk("unlocked", unlocked, m_open);
        chk("unlock_pulse", unlock_pulse, m_up);
        chk("fail_pulse", fail_pulse, m_fp);
        chk("locked_out", locked_out, m_lock > 0);
        chk("attempts_left", attempts_left, m_att);
        chk("pulse_excl", unlock_pulse & fail_pulse, 0);
    endtask

    task automatic tick(input bit r, input bit a, input bit kv, input logic [3:0] kc);
        rst_n = r; arm = a; key_valid = kv; key_code = kc;
        @(posedge clk);
        if (!r) model_reset();
        else model_step();
        #1;
        check_all();
    endtask

    task automatic press(input logic [3:0] kc);
        tick(1, 0, 1, kc);
    endtask

    task automatic idle();
        tick(1, 0, 0, 4'h0);
    endtask

    task automatic set_ref(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        ref_d1 = a; ref_d2 = b; ref_d3 = c; ref_d4 = d;
    endtask

    task automatic code4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        press(a); press(b); press(c); press(d);
    endtask

    initial begin
        int lk;
        logic [3:0] kc;
        set_ref(0, 0, 0, 0);
        // reset, then keys in IDLE
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("rst_attempts", attempts_left, MAXA);
        chk("rst_disp1", disp_d1, 4'hF);
        code4(1, 2, 3, 4);
        press(ENT);
        idle();
        chk("idle_cnt", entry_cnt, 0);
        chk("idle_armed", armed, 0);

        // arm 4709 and unlock
        set_ref(4, 7, 0, 9);
        tick(1, 1, 0, 0);
        code4(4, 7, 0, 9);
        chk("disp4_9", disp_d4, 9);
        press(ENT);
        chk("up_in_check", unlock_pulse, 0);
        idle();
        chk("up_first_open", unlock_pulse, 1);
        idle();
        chk("up_one_cycle", unlock_pulse, 0);
        chk("open_level", unlocked, 1);
        press(RLK);
        chk("relock_unl", unlocked, 0);
        chk("relock_cnt", entry_cnt, 0);

        // three wrong codes, lockout with keys/arm ignored
        for (int i = 0; i < 3; i++) begin
            code4(1, 1, 1, 1);
            press(ENT);
            idle();
            chk("wrong_fp", fail_pulse, 1);
            chk("wrong_att", attempts_left, MAXA - 1 - i);
        end
        set_ref(9, 9, 9, 9);
        lk = locked_out ? 1 : 0;
        for (int i = 0; i < 12; i++) begin
            if (m_lock > 0) tick(1, 1'($urandom % 2), 1, 4'($urandom % 16));
            else idle();
            lk += locked_out ? 1 : 0;
        end
        chk("lock_len", lk, LOCKC);
        chk("post_lock_att", attempts_left, MAXA);
        code4(4, 7, 0, 9);
        press(ENT);
        idle();
        chk("post_lock_unlock", unlocked, 1);
        press(RLK);

        // entry edge cases
        code4(4, 7, 0, 9);
        press(5);
        chk("fifth_ignored", disp_d4, 9);
        press(CLR);
        code4(4, 7, 0, 4'hF);
        press(ENT);
        idle();
        chk("enter3_no_fail", fail_pulse, 0);
        chk("enter3_cnt", entry_cnt, 3);
        press(CLR);
        press(4); press(7); press(CLR);
        chk("clear_d1", disp_d1, 4'hF);
        chk("clear_cnt", entry_cnt, 0);
        code4(4, 7, 0, 9);
        press(ENT);
        idle();
        chk("reenter_unlock", unlock_pulse, 1);

        // snapshot held, arm beats key
        set_ref(1, 2, 3, 4);
        tick(1, 1, 1, 5);
        chk("arm_drops_key", entry_cnt, 0);
        set_ref(5, 6, 7, 8);
        code4(1, 2, 3, 4);
        press(ENT);
        idle();
        chk("snap_old_ok", unlocked, 1);
        press(RLK);
        code4(5, 6, 7, 8);
        press(ENT);
        idle();
        chk("snap_new_fail", fail_pulse, 1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            set_ref(4'($urandom % 10), 4'($urandom % 10), 4'($urandom % 10), 4'($urandom % 10));
            case ($urandom % 8)
                0, 1, 2, 3: kc = ent.size() < 4 ? 4'(snap[ent.size()]) : ENT;
                4: kc = ENT;
                5: kc = CLR;
                6: kc = RLK;
                default: kc = 4'($urandom % 16);
            endcase
            tick(($urandom % 150) != 0, ($urandom % 25) == 0, 1'($urandom % 2), kc);
        end

        // reset mid-lockout
        set_ref(4, 7, 0, 9);
        tick(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            code4(2, 2, 2, 2);
            press(ENT);
            idle();
        end
        idle();
        chk("in_lockout", locked_out, 1);
        tick(0, 0, 0, 0);
        chk("rst_lock_armed", armed, 0);
        chk("rst_lock_lo", locked_out, 0);

        // reset mid-check
        tick(1, 1, 0, 0);
        code4(4, 7, 0, 9);
        press(ENT);
        tick(0, 0, 0, 0);
        chk("rst_check_up", unlock_pulse, 0);
        chk("rst_check_armed", armed, 0);
        idle();
        chk("rst_check_unl", unlocked, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
